// File: rtl/lif_neuron_cfg.sv
// rtl/lif_neuron_cfg.sv - configurable leaky-integrate-and-fire neuron cell
// Optional subtractive (soft) reset on fire is selected with `define LIF_SOFT_RESET_EN.
module lif_neuron_cfg #(
  parameter int WIDTH        = 8,
  parameter int SHIFT_W      = 3,
  parameter int REFRAC_W     = 4,
  parameter int THRESH_RESET = 200,
  parameter int LEAK_RESET   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [WIDTH-1:0]    current,
  input  logic                cfg_we,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [SHIFT_W-1:0]  cfg_leak_shift,
  input  logic [REFRAC_W-1:0] cfg_refrac,
  output logic [WIDTH-1:0]    state,
  output logic                spike,
  output logic                refractory
);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [WIDTH-1:0]    thr_q;
  logic [SHIFT_W-1:0]  leak_q;
  logic [REFRAC_W-1:0] refrac_len_q;
  logic [REFRAC_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    state_q, state_d;
  logic                spike_q, spike_d;

  logic [31:0]         leak_amt;
  logic [WIDTH-1:0]    leak_term;
  logic [WIDTH:0]      sum_wide;
  logic [WIDTH-1:0]    sum_sat;
  logic [WIDTH-1:0]    fire_value;
  logic                fire;

  // Shifts of WIDTH or more must give a clean zero leak term.
  assign leak_amt  = {{(32-SHIFT_W){1'b0}}, leak_q};
  assign leak_term = (leak_amt >= 32'(WIDTH)) ? '0 : (state_q >> leak_q);
  assign sum_wide  = {1'b0, leak_term} + {1'b0, current};
  assign sum_sat   = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
  assign fire      = en && (fsm_q == INTEGRATE) && (sum_sat >= thr_q);

`ifdef LIF_SOFT_RESET_EN
  assign fire_value = sum_sat - thr_q;
`else
  assign fire_value = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= INTEGRATE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (en) begin
      case (fsm_q)
        INTEGRATE: begin
          if (fire && (refrac_len_q != '0)) begin
            fsm_d = REFRACTORY;
          end
        end
        REFRACTORY: begin
          if (cnt_q <= REFRAC_W'(1)) begin
            fsm_d = INTEGRATE;
          end
        end
        default: fsm_d = INTEGRATE;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    if (en) begin
      case (fsm_q)
        INTEGRATE: begin
          if (fire) begin
            state_d = fire_value;
            spike_d = 1'b1;
            if (refrac_len_q != '0) begin
              cnt_d = refrac_len_q;
            end
          end else begin
            state_d = sum_sat;
          end
        end
        REFRACTORY: begin
          // Soft reset keeps the residue parked here until integration resumes.
`ifndef LIF_SOFT_RESET_EN
          state_d = '0;
`endif
          cnt_d = cnt_q - REFRAC_W'(1);
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  // A config write in the same cycle as a step only takes effect after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q        <= WIDTH'(THRESH_RESET);
      leak_q       <= SHIFT_W'(LEAK_RESET);
      refrac_len_q <= '0;
    end else if (cfg_we) begin
      thr_q        <= cfg_threshold;
      leak_q       <= cfg_leak_shift;
      refrac_len_q <= cfg_refrac;
    end
  end

  assign state      = state_q;
  assign spike      = spike_q;
  assign refractory = (fsm_q == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron_cfg.sv
// tb/tb_lif_neuron_cfg.sv - directed vector bench for lif_neuron_cfg
module tb_lif_neuron_cfg;

`ifdef LIF_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] current = '0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_threshold = '0;
  logic [2:0] cfg_leak_shift = '0;
  logic [3:0] cfg_refrac = '0;
  logic [7:0] state;
  logic       spike;
  logic       refractory;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] cur;
    logic       we;
    logic [7:0] thr;
    logic [2:0] leak;
    logic [3:0] rf;
    logic [7:0] st;
    logic       sp;
    logic       rq;
  } vec_t;

  vec_t vecs[$];

  lif_neuron_cfg #(
    .WIDTH(8), .SHIFT_W(3), .REFRAC_W(4), .THRESH_RESET(200), .LEAK_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold),
    .cfg_leak_shift(cfg_leak_shift), .cfg_refrac(cfg_refrac),
    .state(state), .spike(spike), .refractory(refractory)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [7:0] c,
                     input logic w, input logic [7:0] t, input logic [2:0] l,
                     input logic [3:0] f, input logic [7:0] s, input logic p,
                     input logic q);
    vec_t v;
    v.rst = r; v.en = e; v.cur = c; v.we = w; v.thr = t; v.leak = l; v.rf = f;
    v.st = s; v.sp = p; v.rq = q;
    vecs.push_back(v);
  endtask

  task automatic run(input logic [7:0] c, input logic [7:0] s, input logic p, input logic q);
    add(1'b0, 1'b1, c, 1'b0, 8'd0, 3'd0, 4'd0, s, p, q);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive_step(input logic e, input logic [7:0] c, input logic w,
                            input logic [7:0] t, input logic [2:0] l, input logic [3:0] f);
    en = e; current = c; cfg_we = w; cfg_threshold = t; cfg_leak_shift = l; cfg_refrac = f;
    @(posedge clk);
    #1;
    en = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    int t1[9];
    int t2[6];
    t1 = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
    t2 = '{101, 151, 176, 189, 195, 198};

    // plateau below threshold: never fires
    for (int i = 0; i < 9; i++)
      add(i == 0, 1'b1, 8'd100, 1'b0, 8'd0, 3'd0, 4'd0, 8'(t1[i]), 1'b0, 1'b0);

    // fires on 7th step, en=0 drops spike and holds, then period restarts
    for (int i = 0; i < 6; i++)
      add(i == 0, 1'b1, 8'd101, 1'b0, 8'd0, 3'd0, 4'd0, 8'(t2[i]), 1'b0, 1'b0);
    run(8'd101, 8'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'd101, 1'b0, 8'd0, 3'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    run(8'd101, 8'd101, 1'b0, 1'b0);
    run(8'd101, 8'd151, 1'b0, 1'b0);

    // refractory length 3, reprogrammed to 1 mid-refractory
    add(1'b1, 1'b0, 8'd0, 1'b1, 8'd10, 3'd1, 4'd3, 8'd0, 1'b0, 1'b0);
    run(8'd20, SOFT ? 8'd10 : 8'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'd20, 1'b1, 8'd10, 3'd1, 4'd1, SOFT ? 8'd10 : 8'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd20, 1'b0, 8'd0, 3'd0, 4'd0, SOFT ? 8'd10 : 8'd0, 1'b0, 1'b1);
    run(8'd20, SOFT ? 8'd10 : 8'd0, 1'b0, 1'b1);
    run(8'd20, SOFT ? 8'd10 : 8'd0, 1'b0, 1'b0);
    run(8'd20, SOFT ? 8'd15 : 8'd0, 1'b1, 1'b1);
    run(8'd20, SOFT ? 8'd15 : 8'd0, 1'b0, 1'b0);
    run(8'd20, SOFT ? 8'd17 : 8'd0, 1'b1, 1'b1);

    // saturation to 255 fires at threshold 255
    add(1'b1, 1'b0, 8'd0, 1'b1, 8'd255, 3'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    run(8'd200, 8'd200, 1'b0, 1'b0);
    run(8'd200, 8'd0, 1'b1, 1'b0);

    // residue handling, no refractory
    add(1'b1, 1'b0, 8'd0, 1'b1, 8'd100, 3'd0, 4'd0, 8'd0, 1'b0, 1'b0);
    run(8'd70, 8'd70, 1'b0, 1'b0);
    run(8'd70, SOFT ? 8'd40 : 8'd0, 1'b1, 1'b0);
    run(8'd70, SOFT ? 8'd10 : 8'd70, SOFT, 1'b0);
    run(8'd70, SOFT ? 8'd80 : 8'd0, !SOFT, 1'b0);

    // threshold 0 fires every step
    add(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 3'd1, 4'd0, 8'd0, 1'b0, 1'b0);
    run(8'd5, SOFT ? 8'd5 : 8'd0, 1'b1, 1'b0);
    run(8'd5, SOFT ? 8'd7 : 8'd0, 1'b1, 1'b0);
    run(8'd5, SOFT ? 8'd8 : 8'd0, 1'b1, 1'b0);

    // config written alongside a step: that step still sees threshold 200
    add(1'b1, 1'b1, 8'd150, 1'b1, 8'd100, 3'd1, 4'd0, 8'd150, 1'b0, 1'b0);
    run(8'd30, SOFT ? 8'd5 : 8'd0, 1'b1, 1'b0);

    // largest leak shift
    add(1'b1, 1'b0, 8'd0, 1'b1, 8'd255, 3'd7, 4'd0, 8'd0, 1'b0, 1'b0);
    run(8'd200, 8'd200, 1'b0, 1'b0);
    run(8'd10, 8'd11, 1'b0, 1'b0);

    // reset state, checked without any clock edge
    #1;
    chk("rst_state", 0, 32'(state), 32'd0);
    chk("rst_spike", 0, 32'(spike), 32'd0);
    chk("rst_refr", 0, 32'(refractory), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      drive_step(vecs[i].en, vecs[i].cur, vecs[i].we, vecs[i].thr, vecs[i].leak, vecs[i].rf);
      chk("vec_state", i, 32'(state), 32'(vecs[i].st));
      chk("vec_spike", i, 32'(spike), 32'(vecs[i].sp));
      chk("vec_refr", i, 32'(refractory), 32'(vecs[i].rq));
    end

    // asynchronous reset in the middle of a refractory period
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive_step(1'b0, 8'd0, 1'b1, 8'd10, 3'd1, 4'd3);
    drive_step(1'b1, 8'd20, 1'b0, 8'd0, 3'd0, 4'd0);
    drive_step(1'b1, 8'd20, 1'b0, 8'd0, 3'd0, 4'd0);
    chk("mid_refr", 0, 32'(refractory), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 0, 32'(state), 32'd0);
    chk("async_spike", 0, 32'(spike), 32'd0);
    chk("async_refr", 0, 32'(refractory), 32'd0);
    #1;
    rst_n = 1'b1;
    drive_step(1'b1, 8'd50, 1'b0, 8'd0, 3'd0, 4'd0);
    chk("post_state", 0, 32'(state), 32'd50);
    chk("post_refr", 0, 32'(refractory), 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive_step(1'b0, 8'd99, 1'b0, 8'd0, 3'd0, 4'd0);
      chk("hold_state", k, 32'(state), 32'd50);
      chk("hold_spike", k, 32'(spike), 32'd0);
    end
    drive_step(1'b1, 8'd150, 1'b0, 8'd0, 3'd0, 4'd0);
    chk("thr_default_state", 0, 32'(state), 32'd175);
    chk("thr_default_spike", 0, 32'(spike), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
